// File: rtl/flow_light_ctrl.sv
// Flowing-water-light sequencer: prescaler tick plus run/direction FSM.
// Drives the enable, up/down and clear inputs of an external up/down position
// counter, keeps a shadow copy of the position and decodes it onto the LEDs.
//
// state | meaning
// IDLE  | stopped; prescaler held at 0, waiting for start
// UP    | stepping upward, one step per prescaler tick
// DOWN  | stepping downward, one step per prescaler tick
module flow_light_ctrl #(
  parameter int POS_BITS = 3,
  parameter int PERIOD   = 12500000,
  parameter int DIV_BITS = 27
) (
  input  logic                     clk,
  input  logic                     r,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     mode,
  input  logic                     dir_init,
  input  logic [1:0]               speed,
  output logic                     cnt_en,
  output logic                     cnt_ud,
  output logic                     cnt_r,
  output logic [POS_BITS-1:0]      pos,
  output logic [2**POS_BITS-1:0]   led,
  output logic                     running
);

  localparam int LEDS = 2**POS_BITS;
  localparam logic [POS_BITS-1:0] POS_MAX  = '1;
  localparam logic [POS_BITS-1:0] POS_ONE  = POS_BITS'(1);
  localparam logic [LEDS-1:0]     LED_ONE  = LEDS'(1);
  localparam logic [DIV_BITS-1:0] DIV_BASE = DIV_BITS'(PERIOD);
  localparam logic [DIV_BITS-1:0] DIV_ONE  = DIV_BITS'(1);

  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

  state_t              state;
  state_t              step_state;
  logic [POS_BITS-1:0] step_pos;
  logic [DIV_BITS-1:0] presc;
  logic [DIV_BITS-1:0] term;
  logic [1:0]          speed_q;
  logic                tick;

  // Terminal count for the selected speed; a speed change suppresses the tick.
  always_comb begin
    term = (DIV_BASE << speed) - DIV_ONE;
    tick = (state != IDLE) && (speed == speed_q) && (presc == term);
  end

  // Next position/direction for a step, including bounce reversal at the ends.
  always_comb begin
    step_pos   = pos;
    step_state = state;
    if (state == UP) begin
      if (mode && (pos == POS_MAX)) begin
        step_state = DOWN;
        step_pos   = POS_MAX - POS_ONE;
      end else begin
        step_pos = pos + POS_ONE;
      end
    end else if (state == DOWN) begin
      if (mode && (pos == '0)) begin
        step_state = UP;
        step_pos   = POS_ONE;
      end else begin
        step_pos = pos - POS_ONE;
      end
    end
  end

  // Run/direction FSM with prescaler and all registered outputs.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state   <= IDLE;
      presc   <= '0;
      speed_q <= 2'd0;
      pos     <= '0;
      led     <= LED_ONE;
      cnt_en  <= 1'b0;
      cnt_ud  <= 1'b1;
      cnt_r   <= 1'b1;
      running <= 1'b0;
    end else begin
      speed_q <= speed;
      cnt_en  <= 1'b0;
      cnt_r   <= 1'b0;
      case (state)
        IDLE: begin
          presc <= '0;
          if (start && !stop) begin
            state   <= dir_init ? UP : DOWN;
            cnt_ud  <= dir_init;
            pos     <= '0;
            led     <= LED_ONE;
            cnt_r   <= 1'b1;
            running <= 1'b1;
          end
        end
        default: begin
          if (stop) begin
            // Position is held and the counter is not cleared, so both stay in step.
            state   <= IDLE;
            presc   <= '0;
            running <= 1'b0;
          end else if (speed != speed_q) begin
            presc <= '0;
          end else if (tick) begin
            presc  <= '0;
            cnt_en <= 1'b1;
            cnt_ud <= (step_state == UP);
            pos    <= step_pos;
            led    <= LED_ONE << step_pos;
            state  <= step_state;
          end else begin
            presc <= presc + DIV_ONE;
          end
        end
      endcase
    end
  end

endmodule
